// File: rtl/llsc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : llsc_ctrl                                                     |
// | Purpose  : MIPS LL/SC sequencer for the EXE/MEM stage. Owns the LLbit    |
// |            and link address, issues the LL load / SC store on a req/ack  |
// |            data-memory port and returns the rt write-back value.         |
// | Options  : LLSC_SNOOP_EN - when defined, stores reported on snoop_* that |
// |            hit the linked granule break the link. When undefined the     |
// |            snoop ports are ignored.                                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module llsc_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int GRAN     = 2,
  parameter int LINK_TTL = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ll_req,
  input  logic              sc_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy_o,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              ll_bit_o,
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr
);

  // TTL counter sized to hold LINK_TTL; a disabled TTL keeps a 1-bit stub.
  localparam int               c_ttl_w    = (LINK_TTL > 0) ? $clog2(LINK_TTL + 1) : 1;
  localparam bit               c_ttl_en   = (LINK_TTL > 0);
  localparam logic [c_ttl_w-1:0] c_ttl_max  = c_ttl_w'(LINK_TTL);
  localparam logic [c_ttl_w-1:0] c_ttl_last = c_ttl_w'((LINK_TTL > 0) ? LINK_TTL - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LL_MEM = 2'd1,
    ST_SC_MEM = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_squash;     // flush seen while the bus op was in flight
  logic                  r_resp_valid;
  logic [DATA_W-1:0]     r_resp_data;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic                  r_ll_bit;
  logic [ADDR_W-1:GRAN]  r_link_tag;
  logic [c_ttl_w-1:0]    r_ttl;

  logic w_idle;
  logic w_accept_ll;
  logic w_accept_sc;
  logic w_sc_ok;
  logic w_snoop_hit;
  logic w_ll_done;
  logic w_sc_done;
  logic w_ttl_expire;

`ifdef LLSC_SNOOP_EN
  // Only the granule-aligned part of the address takes part in the compare.
  assign w_snoop_hit = snoop_valid && (snoop_addr[ADDR_W-1:GRAN] == r_link_tag);

  generate
    if (GRAN > 0) begin : g_snoop_lsb
      logic w_unused_snoop_lsb;
      assign w_unused_snoop_lsb = ^snoop_addr[GRAN-1:0];
    end
  endgenerate
`else
  assign w_snoop_hit = 1'b0;

  logic w_unused_snoop;
  assign w_unused_snoop = ^{snoop_valid, snoop_addr, r_link_tag};
`endif

  // A flush in the request cycle swallows the request; LL beats SC when both arrive.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_accept_ll = w_idle && ll_req && !flush;
  assign w_accept_sc = w_idle && sc_req && !ll_req && !flush;

  // The SC outcome is decided here, once; a snoop hitting in this cycle fails it.
  assign w_sc_ok     = r_ll_bit && !w_snoop_hit;

  assign w_ll_done   = (r_state == ST_LL_MEM) && mem_ack;
  assign w_sc_done   = (r_state == ST_SC_MEM) && mem_ack;

  // Link expires after LINK_TTL cycles with the LLbit set.
  assign w_ttl_expire = c_ttl_en && r_ll_bit && (r_ttl == c_ttl_last);

  assign busy_o     = !w_idle || w_accept_ll || w_accept_sc;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  // A flush landing in the response cycle kills the write-back.
  assign resp_valid = r_resp_valid && !flush;
  assign resp_data  = r_resp_data;
  assign ll_bit_o   = r_ll_bit;

  // Sequencer: accept LL/SC, hold the bus request until ack, emit one response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_squash     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_squash <= 1'b0;
          if (w_accept_ll) begin
            r_state     <= ST_LL_MEM;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= addr;
            r_mem_wdata <= '0;
          end else if (w_accept_sc && w_sc_ok) begin
            r_state     <= ST_SC_MEM;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= addr;
            r_mem_wdata <= wdata;
          end else if (w_accept_sc) begin
            // Link already broken: fail without touching memory.
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_data  <= '0;
          end
        end

        ST_LL_MEM, ST_SC_MEM: begin
          // The bus transaction always runs to completion, even after a flush.
          if (flush) begin
            r_squash <= 1'b1;
          end
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            if (flush || r_squash) begin
              r_state <= ST_IDLE;
            end else begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_data  <= (r_state == ST_LL_MEM) ? mem_rdata : DATA_W'(1);
            end
          end
        end

        ST_RESP: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // LLbit, link address and TTL: flush > LL set > SC/snoop/TTL clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ll_bit   <= 1'b0;
      r_link_tag <= '0;
      r_ttl      <= '0;
    end else begin
      if (flush) begin
        r_ll_bit <= 1'b0;
      end else if (w_ll_done && !r_squash) begin
        r_ll_bit   <= 1'b1;
        r_link_tag <= r_mem_addr[ADDR_W-1:GRAN];
      end else if (w_sc_done || w_snoop_hit || w_ttl_expire) begin
        r_ll_bit <= 1'b0;
      end

      if (!flush && w_ll_done && !r_squash) begin
        r_ttl <= '0;
      end else if (r_ll_bit && (r_ttl != c_ttl_max)) begin
        r_ttl <= r_ttl + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_llsc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_llsc_ctrl                                                  |
// | Purpose  : Self-checking bench for llsc_ctrl. A transaction-level model  |
// |            predicts latency, response data, bus activity and the LLbit   |
// |            (as a link flag with an expiry cycle) for directed and random |
// |            LL/SC/flush/snoop sequences.                                  |
// | Options  : follows LLSC_SNOOP_EN of the design build.                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_llsc_ctrl;

  localparam int TTL    = 8;
  localparam int GRAN_B = 2;
`ifdef LLSC_SNOOP_EN
  localparam bit SNOOP_ON = 1'b1;
`else
  localparam bit SNOOP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        ll_req = 1'b0;
  logic        sc_req = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy_o;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        ll_bit_o;
  logic        snoop_valid = 1'b0;
  logic [31:0] snoop_addr = '0;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: link flag, linked address, first cycle the link is gone by age.
  int          cyc = 0;
  bit          m_bit = 1'b0;
  logic [31:0] m_tag = '0;
  int          m_expire = 0;

  llsc_ctrl #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .GRAN    (GRAN_B),
    .LINK_TTL(TTL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .ll_req     (ll_req),
    .sc_req     (sc_req),
    .addr       (addr),
    .wdata      (wdata),
    .busy_o     (busy_o),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .ll_bit_o   (ll_bit_o),
    .snoop_valid(snoop_valid),
    .snoop_addr (snoop_addr)
  );

  always #5 clk = ~clk;

  function automatic bit exp_bit(input int k);
    return m_bit && ((TTL == 0) || (k < m_expire));
  endfunction

  function automatic bit snoop_hits(input logic [31:0] sa);
    return SNOOP_ON && ((sa >> GRAN_B) == (m_tag >> GRAN_B));
  endfunction

  // Apply the link events of the current cycle; they become visible next cycle.
  task automatic model_update(input bit fl, input bit set_ev, input logic [31:0] set_a,
                              input bit clr_ev);
    if (!exp_bit(cyc)) m_bit = 1'b0;
    if (fl) begin
      m_bit = 1'b0;
    end else if (set_ev) begin
      m_bit    = 1'b1;
      m_tag    = set_a;
      m_expire = cyc + 1 + TTL;
    end else if (clr_ev) begin
      m_bit = 1'b0;
    end
    cyc++;
  endtask

  // Drive one cycle of inputs at the falling edge, settle, then let the caller sample.
  task automatic drive(input logic d_ll, input logic d_sc, input logic d_fl,
                       input logic [31:0] d_a, input logic [31:0] d_wd,
                       input logic d_sv, input logic [31:0] d_sa,
                       input logic d_ack, input logic [31:0] d_rd);
    @(negedge clk);
    ll_req      = d_ll;
    sc_req      = d_sc;
    flush       = d_fl;
    addr        = d_a;
    wdata       = d_wd;
    snoop_valid = d_sv;
    snoop_addr  = d_sa;
    mem_ack     = d_ack;
    mem_rdata   = d_rd;
    #1;
  endtask

  // One operation. kind: 0=LL 1=SC 2=LL+SC together 3=idle for lat+1 cycles.
  // Memory acks on request cycle lat+1. fl_at/sn_at: cycle offset of flush/snoop (-1 none).
  task automatic run_op(input string nm, input int kind, input logic [31:0] a,
                        input logic [31:0] wd, input int lat, input int fl_at,
                        input int sn_at, input logic [31:0] sn_a, input logic [31:0] rd);
    bit is_ll, accepted, link_ok, to_mem, mem_squash, resp_ok, sn_now;
    bit e_busy, e_req, e_rv, e_bit;
    int ack_at, resp_at, end_at, n_cyc;
    logic [31:0] exp_data;
    is_ll      = (kind == 0) || (kind == 2);
    accepted   = (kind != 3) && (fl_at != 0);
    link_ok    = exp_bit(cyc) && !((sn_at == 0) && snoop_hits(sn_a));
    to_mem     = accepted && (is_ll || link_ok);
    ack_at     = to_mem ? lat + 1 : 0;
    resp_at    = to_mem ? lat + 2 : 1;
    mem_squash = to_mem && (fl_at >= 1) && (fl_at <= ack_at);
    resp_ok    = accepted && !mem_squash && (fl_at != resp_at);
    end_at     = mem_squash ? ack_at : resp_at;
    n_cyc      = accepted ? end_at + 2 : ((kind == 3) ? lat + 1 : 2);
    exp_data   = is_ll ? rd : (link_ok ? 32'd1 : 32'd0);
    for (int j = 0; j < n_cyc; j++) begin
      sn_now = (j == sn_at);
      drive((j == 0) && is_ll, (j == 0) && ((kind == 1) || (kind == 2)), (j == fl_at),
            a, wd, sn_now, sn_a, to_mem && (j == ack_at),
            (to_mem && (j == ack_at)) ? rd : ~rd);
      e_busy = accepted && (j <= end_at);
      e_req  = to_mem && (j >= 1) && (j <= ack_at);
      e_rv   = resp_ok && (j == resp_at);
      e_bit  = exp_bit(cyc);
      n_checks++;
      if (busy_o !== e_busy)
        $display("FAIL %s c%0d busy_o: got %b want %b", nm, j, busy_o, e_busy);
      else n_pass++;
      n_checks++;
      if (mem_req !== e_req)
        $display("FAIL %s c%0d mem_req: got %b want %b", nm, j, mem_req, e_req);
      else n_pass++;
      if (e_req) begin
        n_checks++;
        if ((mem_we !== !is_ll) || (mem_addr !== a))
          $display("FAIL %s c%0d mem_we/addr: got %b/%h want %b/%h", nm, j, mem_we,
                   mem_addr, !is_ll, a);
        else n_pass++;
        if (!is_ll) begin
          n_checks++;
          if (mem_wdata !== wd)
            $display("FAIL %s c%0d mem_wdata: got %h want %h", nm, j, mem_wdata, wd);
          else n_pass++;
        end
      end
      n_checks++;
      if (resp_valid !== e_rv)
        $display("FAIL %s c%0d resp_valid: got %b want %b", nm, j, resp_valid, e_rv);
      else n_pass++;
      if (e_rv) begin
        n_checks++;
        if (resp_data !== exp_data)
          $display("FAIL %s c%0d resp_data: got %h want %h", nm, j, resp_data, exp_data);
        else n_pass++;
      end
      n_checks++;
      if (ll_bit_o !== e_bit)
        $display("FAIL %s c%0d ll_bit_o: got %b want %b", nm, j, ll_bit_o, e_bit);
      else n_pass++;
      model_update(j == fl_at, is_ll && to_mem && (j == ack_at) && !mem_squash, a,
                   (!is_ll && to_mem && (j == ack_at)) || (sn_now && snoop_hits(sn_a)));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({busy_o, mem_req, mem_we, resp_valid, ll_bit_o} !== 5'b0)
      $display("FAIL reset flags: got %b want 00000",
               {busy_o, mem_req, mem_we, resp_valid, ll_bit_o});
    else n_pass++;
    n_checks++;
    if ({mem_addr, mem_wdata, resp_data} !== 96'b0)
      $display("FAIL reset buses: got %h/%h/%h want 0", mem_addr, mem_wdata, resp_data);
    else n_pass++;
    rst_n = 1'b1;
    run_op("post_reset_idle", 3, 32'h0, 32'h0, 2, -1, -1, 32'h0, 32'h0);
  endtask

  task automatic test_ll_sc();
    run_op("T1_ll", 0, 32'h100, 32'h0, 1, -1, -1, 32'h0, 32'hDEAD_BEEF);
    run_op("T2_sc", 1, 32'h100, 32'h5, 0, -1, -1, 32'h0, 32'h0);
  endtask

  task automatic test_failed_sc();
    run_op("T3_sc_nolink", 1, 32'h100, 32'h7, 2, -1, -1, 32'h0, 32'h0);
    run_op("sc_fail_flush_resp", 1, 32'h100, 32'h7, 0, 1, -1, 32'h0, 32'h0);
  endtask

  task automatic test_flush();
    run_op("T4_flush_ll_mem", 0, 32'h140, 32'h0, 3, 2, -1, 32'h0, 32'h1111_2222);
    run_op("flush_at_accept", 0, 32'h140, 32'h0, 1, 0, -1, 32'h0, 32'h3333_4444);
    run_op("ll_for_flush_resp", 0, 32'h180, 32'h0, 0, -1, -1, 32'h0, 32'h5555_6666);
    run_op("flush_in_resp_ll", 0, 32'h180, 32'h0, 0, 2, -1, 32'h0, 32'h7777_8888);
    run_op("ll_for_sc_flush", 0, 32'h1C0, 32'h0, 0, -1, -1, 32'h0, 32'h9999_0000);
    run_op("flush_sc_on_bus", 1, 32'h1C0, 32'hCAFE, 2, 1, -1, 32'h0, 32'h0);
    run_op("flush_at_ack_ll", 0, 32'h1C0, 32'h0, 1, 2, -1, 32'h0, 32'hABCD_0123);
  endtask

  task automatic test_snoop();
    run_op("T5_ll", 0, 32'h100, 32'h0, 0, -1, -1, 32'h0, 32'h0102_0304);
    run_op("T5_snoop_other", 3, 32'h0, 32'h0, 1, -1, 1, 32'h104, 32'h0);
    run_op("T5_sc_kept", 1, 32'h100, 32'h11, 0, -1, -1, 32'h0, 32'h0);
    run_op("T5_ll2", 0, 32'h100, 32'h0, 1, -1, -1, 32'h0, 32'h0506_0708);
    run_op("T5_snoop_same", 3, 32'h0, 32'h0, 1, -1, 0, 32'h102, 32'h0);
    run_op("T5_sc_after_snoop", 1, 32'h100, 32'h22, 0, -1, -1, 32'h0, 32'h0);
    run_op("ll_for_accept_snoop", 0, 32'h200, 32'h0, 0, -1, -1, 32'h0, 32'h1);
    run_op("snoop_in_sc_accept", 1, 32'h200, 32'h33, 1, -1, 0, 32'h203, 32'h0);
    run_op("ll_for_snoop_scmem", 0, 32'h200, 32'h0, 0, -1, -1, 32'h0, 32'h2);
    run_op("snoop_in_sc_mem", 1, 32'h200, 32'h44, 2, -1, 2, 32'h200, 32'h0);
  endtask

  task automatic test_ttl();
    run_op("T6_ll", 0, 32'h300, 32'h0, 0, -1, -1, 32'h0, 32'hFEED_F00D);
    run_op("T6_idle", 3, 32'h0, 32'h0, 9, -1, -1, 32'h0, 32'h0);
    run_op("T6_sc_expired", 1, 32'h300, 32'h9, 0, -1, -1, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    run_op("ll_and_sc_same_cycle", 2, 32'h400, 32'h66, 1, -1, -1, 32'h0, 32'h0BAD_CAFE);
    run_op("sc_right_after", 1, 32'h400, 32'h77, 3, -1, -1, 32'h0, 32'h0);
  endtask

  task automatic test_async_reset();
    run_op("T6_ll_pre_rst", 0, 32'h200, 32'h0, 0, -1, -1, 32'h0, 32'h1234_5678);
    drive(1'b0, 1'b1, 1'b0, 32'h200, 32'hA5A5_0001, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h200, 32'hA5A5_0001, 1'b0, 32'h0, 1'b0, 32'h0);
    n_checks++;
    if ((mem_req !== 1'b1) || (mem_we !== 1'b1))
      $display("FAIL rst_sc_on_bus: got req/we %b/%b want 1/1", mem_req, mem_we);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy_o, mem_req, mem_we, resp_valid, ll_bit_o} !== 5'b0)
      $display("FAIL async_rst flags: got %b want 00000",
               {busy_o, mem_req, mem_we, resp_valid, ll_bit_o});
    else n_pass++;
    n_checks++;
    if ({mem_addr, mem_wdata, resp_data} !== 96'b0)
      $display("FAIL async_rst buses: got %h/%h/%h want 0", mem_addr, mem_wdata, resp_data);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    m_bit = 1'b0;
    m_tag = '0;
    cyc   = cyc + 3;
    run_op("post_async_rst_sc", 1, 32'h200, 32'h1, 0, -1, -1, 32'h0, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] pool [5];
    int          r, kind, lat, fl_at, sn_at;
    pool = '{32'h100, 32'h102, 32'h104, 32'h200, 32'h300};
    for (int t = 0; t < 60; t++) begin
      r     = $urandom_range(0, 9);
      kind  = (r < 4) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
      lat   = (kind == 3) ? $urandom_range(0, 9) : $urandom_range(0, 3);
      fl_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, lat + 3) : -1;
      sn_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat + 3) : -1;
      run_op($sformatf("rnd%0d", t), kind, pool[$urandom_range(0, 4)], $urandom(), lat,
             fl_at, sn_at, pool[$urandom_range(0, 4)], $urandom());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ll_sc();
    test_failed_sc();
    test_flush();
    test_snoop();
    test_ttl();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
